// File: rtl/wb_ext_bridge_pkg.sv
// Shared types and constants for the Wishbone to external data port bridge.
package wb_ext_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/wb_ext_data_bridge.sv
// Wishbone classic slave that issues one req/gnt/rvalid transaction per bus
// cycle on the core's external data port, with window decode and timeout.
module wb_ext_data_bridge
    import wb_ext_bridge_pkg::*;
#(
    parameter logic [31:0] WB_BASE    = 32'h3000_0000,
    parameter logic [31:0] WB_MASK    = 32'hFFFF_F000,
    parameter logic [31:0] LOCAL_BASE = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        ext_data_req_o,
    output logic        ext_data_we_o,
    output logic [3:0]  ext_data_be_o,
    output logic [31:0] ext_data_addr_o,
    output logic [31:0] ext_data_wdata_o,
    input  logic        ext_data_gnt_i,
    input  logic        ext_data_rvalid_i,
    input  logic [31:0] ext_data_rdata_i
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIM = TIMEOUT[TMO_CNT_W-1:0];
    localparam logic [TMO_CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t nxt;
    logic [TMO_CNT_W-1:0] cnt;
    logic start;
    logic hit;
    logic timed_out;
    logic enter_tmo;

    assign start     = wbs_cyc_i && wbs_stb_i;
    assign hit       = ((wbs_adr_i ^ WB_BASE) & WB_MASK) == 32'h0;
    assign timed_out = cnt == TMO_LIM;
    assign enter_tmo = (nxt != state) && (nxt == ST_REQ || nxt == ST_WAIT);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) nxt = hit ? ST_REQ : ST_ERR;
            end
            ST_REQ: begin
                if (ext_data_gnt_i) nxt = ST_WAIT;
                else if (timed_out) nxt = ST_ERR;
            end
            ST_WAIT: begin
                if (ext_data_rvalid_i) nxt = ST_ACK;
                else if (timed_out) nxt = ST_ERR;
            end
            default: nxt = ST_IDLE;
        endcase
        // Master abandoned the cycle: finish silently without a response.
        if ((nxt == ST_ACK || nxt == ST_ERR) && !wbs_cyc_i) nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            wbs_ack_o        <= 1'b0;
            wbs_err_o        <= 1'b0;
            wbs_dat_o        <= 32'h0;
            ext_data_req_o   <= 1'b0;
            ext_data_we_o    <= 1'b0;
            ext_data_be_o    <= 4'h0;
            ext_data_addr_o  <= 32'h0;
            ext_data_wdata_o <= 32'h0;
        end else begin
            state          <= nxt;
            ext_data_req_o <= nxt == ST_REQ;
            wbs_ack_o      <= nxt == ST_ACK;
            wbs_err_o      <= nxt == ST_ERR;

            if (enter_tmo) cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

            if (state == ST_IDLE && start && hit) begin
                ext_data_we_o    <= wbs_we_i;
                ext_data_be_o    <= wbs_sel_i;
                ext_data_wdata_o <= wbs_dat_i;
                ext_data_addr_o  <= LOCAL_BASE + (wbs_adr_i & ~WB_MASK);
            end

            if (nxt == ST_ERR)
                wbs_dat_o <= ERR_DATA;
            else if (state == ST_WAIT && ext_data_rvalid_i && !ext_data_we_o)
                wbs_dat_o <= ext_data_rdata_i;
        end
    end

endmodule

// File: tb/tb_wb_ext_data_bridge.sv
// Directed scoreboard bench for wb_ext_data_bridge: stimulus pushes expected
// Wishbone responses, a monitor pops and compares them on ack/err.
module tb_wb_ext_data_bridge;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          at;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic        ext_data_req_o;
    logic        ext_data_we_o;
    logic [3:0]  ext_data_be_o;
    logic [31:0] ext_data_addr_o;
    logic [31:0] ext_data_wdata_o;
    logic        ext_data_gnt_i = 1'b0;
    logic        ext_data_rvalid_i = 1'b0;
    logic [31:0] ext_data_rdata_i = 32'h0;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_n = 0;
    int   k;
    exp_t q[$];

    wb_ext_data_bridge dut (
        .clk_i            (clk_i),
        .reset_n          (reset_n),
        .wbs_cyc_i        (wbs_cyc_i),
        .wbs_stb_i        (wbs_stb_i),
        .wbs_we_i         (wbs_we_i),
        .wbs_sel_i        (wbs_sel_i),
        .wbs_adr_i        (wbs_adr_i),
        .wbs_dat_i        (wbs_dat_i),
        .wbs_ack_o        (wbs_ack_o),
        .wbs_err_o        (wbs_err_o),
        .wbs_dat_o        (wbs_dat_o),
        .ext_data_req_o   (ext_data_req_o),
        .ext_data_we_o    (ext_data_we_o),
        .ext_data_be_o    (ext_data_be_o),
        .ext_data_addr_o  (ext_data_addr_o),
        .ext_data_wdata_o (ext_data_wdata_o),
        .ext_data_gnt_i   (ext_data_gnt_i),
        .ext_data_rvalid_i(ext_data_rvalid_i),
        .ext_data_rdata_i (ext_data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push(input logic err, input logic [31:0] data, input int at);
        exp_t e;
        e.err = err;
        e.data = data;
        e.at = at;
        q.push_back(e);
    endtask

    task automatic bus(input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
    endtask

    task automatic idle_bus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Best-case read starting at the current negedge (cycle 0).
    task automatic best_read(input logic [31:0] adr, input logic [31:0] rd,
                             input logic [31:0] ea, input string tag);
        k = cyc_n;
        bus(1'b0, 4'hF, adr, 32'h0);
        push(1'b0, rd, k + 3);
        tick();
        chk({tag, "_req"}, {31'h0, ext_data_req_o}, 32'h1);
        chk({tag, "_addr"}, ext_data_addr_o, ea);
        ext_data_gnt_i = 1'b1;
        tick();
        ext_data_gnt_i = 1'b0;
        chk({tag, "_req_drop"}, {31'h0, ext_data_req_o}, 32'h0);
        ext_data_rvalid_i = 1'b1;
        ext_data_rdata_i = rd;
        tick();
        ext_data_rvalid_i = 1'b0;
        idle_bus();
        tick();
    endtask

    always @(negedge clk_i) begin
        if (reset_n && (wbs_ack_o || wbs_err_o)) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b dat=%h required none",
                         wbs_ack_o, wbs_err_o, wbs_dat_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (wbs_err_o !== e.err || wbs_ack_o !== !e.err ||
                    wbs_dat_o !== e.data || cyc_n != e.at) begin
                    miscompares++;
                    $display("FAIL resp: got err=%0b ack=%0b dat=%h cyc=%0d required err=%0b dat=%h cyc=%0d",
                             wbs_err_o, wbs_ack_o, wbs_dat_o, cyc_n,
                             e.err, e.data, e.at);
                end
            end
        end
    end

    initial begin
        tick();
        chk("rst_req", {31'h0, ext_data_req_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_addr", ext_data_addr_o, 32'h0);
        chk("rst_ackerr", {30'h0, wbs_ack_o, wbs_err_o}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Read hit, best case
        best_read(32'h3000_0010, 32'h1234_5678, 32'h0000_0010, "rd");
        chk("rd_be", {28'h0, ext_data_be_o}, 32'hF);

        // Write with grant delayed three cycles
        k = cyc_n;
        bus(1'b1, 4'b0011, 32'h3000_0024, 32'hA5A5_A5A5);
        push(1'b0, 32'h1234_5678, k + 6);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("wr_req", {31'h0, ext_data_req_o}, 32'h1);
            chk("wr_be", {28'h0, ext_data_be_o}, 32'h3);
            chk("wr_wdata", ext_data_wdata_o, 32'hA5A5_A5A5);
            if (i == 4) ext_data_gnt_i = 1'b1;
        end
        chk("wr_we", {31'h0, ext_data_we_o}, 32'h1);
        chk("wr_addr", ext_data_addr_o, 32'h0000_0024);
        tick();
        ext_data_gnt_i = 1'b0;
        chk("wr_req_drop", {31'h0, ext_data_req_o}, 32'h0);
        ext_data_rvalid_i = 1'b1;
        ext_data_rdata_i = 32'hFFFF_0000;
        tick();
        ext_data_rvalid_i = 1'b0;
        idle_bus();
        tick();

        // Window miss
        k = cyc_n;
        bus(1'b0, 4'hF, 32'h2000_0000, 32'h0);
        push(1'b1, 32'hDEAD_BEEF, k + 1);
        tick();
        chk("miss_noreq", {31'h0, ext_data_req_o}, 32'h0);
        idle_bus();
        tick();

        // Timeout with grant never given
        k = cyc_n;
        bus(1'b0, 4'hF, 32'h3000_0100, 32'h0);
        push(1'b1, 32'hDEAD_BEEF, k + 257);
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 1 || i == 256)
                chk("tmo_req_held", {31'h0, ext_data_req_o}, 32'h1);
        end
        chk("tmo_req_drop", {31'h0, ext_data_req_o}, 32'h0);
        idle_bus();
        tick();
        ext_data_rvalid_i = 1'b1;
        ext_data_rdata_i = 32'h0000_0BAD;
        tick();
        ext_data_rvalid_i = 1'b0;
        tick();
        chk("stray_dat", wbs_dat_o, 32'hDEAD_BEEF);
        best_read(32'h3000_0020, 32'hCAFE_F00D, 32'h0000_0020, "post_tmo");

        // Master drops cyc while waiting for the response
        bus(1'b0, 4'hF, 32'h3000_0030, 32'h0);
        tick();
        ext_data_gnt_i = 1'b1;
        tick();
        ext_data_gnt_i = 1'b0;
        idle_bus();
        tick();
        ext_data_rvalid_i = 1'b1;
        ext_data_rdata_i = 32'h0BAD_F00D;
        tick();
        ext_data_rvalid_i = 1'b0;
        best_read(32'h3000_0040, 32'h1111_2222, 32'h0000_0040, "post_drop");

        // Reset while requesting
        bus(1'b0, 4'hF, 32'h3000_0050, 32'h0);
        tick();
        chk("prerst_req", {31'h0, ext_data_req_o}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, ext_data_req_o}, 32'h0);
        chk("arst_addr", ext_data_addr_o, 32'h0);
        chk("arst_dat", wbs_dat_o, 32'h0);
        chk("arst_be_we", {27'h0, ext_data_be_o, ext_data_we_o}, 32'h0);
        tick();
        idle_bus();
        reset_n = 1'b1;
        tick();
        best_read(32'h3000_0060, 32'h5A5A_0001, 32'h0000_0060, "post_rst");

        repeat (4) tick();
        chk("drain", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_ext_data_bridge.md
# wb_ext_data_bridge

Wishbone classic slave that turns management-SoC bus cycles into transactions on the core's external data port (req/gnt/rvalid), acting as the initiator for the port the core exposes as a responder. It sits in the user wrapper between the caravel Wishbone bus and the SoC top, so firmware can preload and inspect core data memory. It provides an address window, a no-response timeout and one outstanding transaction.

## Interface
Parameters:
- WB_BASE, 32'h3000_0000, Wishbone address of window start
- WB_MASK, 32'hFFFF_F000, bits that must match WB_BASE for a hit
- LOCAL_BASE, 32'h0000_0000, ext address that window offset 0 maps to
- TIMEOUT, 255, max cycles waiting in REQ or WAIT (8-bit counter)
- ERR_DATA, 32'hDEAD_BEEF, wbs_dat_o value on any error

Ports:
- clk_i  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o, wbs_err_o  out  1 each  one-cycle completion / error
- wbs_dat_o  out  32  read data, valid with ack/err
- ext_data_req_o, ext_data_we_o  out  1 each  request, write enable
- ext_data_be_o  out  4  byte enables
- ext_data_addr_o, ext_data_wdata_o  out  32 each  address, write data
- ext_data_gnt_i, ext_data_rvalid_i  in  1 each  grant, response valid
- ext_data_rdata_i  in  32  response data

## Operation
- States: IDLE, REQ, WAIT, ACK, ERR.
- IDLE: on cyc&stb, hit = ((adr ^ WB_BASE) & WB_MASK) == 0. Hit -> latch we, sel, dat, addr_o = LOCAL_BASE + (adr & ~WB_MASK); go REQ. Miss -> go ERR, no ext request.
- REQ: req_o=1 with stable we/be/addr/wdata until gnt_i sampled 1 -> WAIT. Counter reaches TIMEOUT -> ERR (req dropped).
- WAIT: req_o=0; rvalid_i=1 -> capture rdata_i (reads only; writes leave dat_o unchanged), go ACK. Timeout -> ERR. rvalid required for writes too.
- ACK: ack_o=1 one cycle, -> IDLE. ERR: err_o=1, dat_o=ERR_DATA one cycle, -> IDLE.
- cyc_i low on reaching ACK/ERR: ext transaction still completed, ack_o/err_o suppressed, -> IDLE.
- rvalid_i outside WAIT (late response after timeout) ignored. One outstanding transaction max; stb in non-IDLE states ignored.
- Timeout counter cleared on every entry to REQ and WAIT; saturates, never wraps.

## Timing
- Reset: state IDLE; all outputs 0 (req, we, be, addr, wdata, ack, err, dat_o); counter 0. Reset mid-transaction abandons it immediately, no ack.
- All outputs registered. stb at cycle 0 -> req_o at cycle 1.
- gnt_i same cycle as req_o -> req_o low next cycle; rvalid earliest the cycle after gnt.
- Best-case read: stb cycle 0, req/gnt cycle 1, rvalid cycle 2, ack cycle 3 -> 4-cycle Wishbone latency.
- Miss: err_o in cycle 1.
- Timeout: err_o TIMEOUT+1 cycles after entering the stalled state.
- Back-to-back: new stb sampled in the IDLE cycle right after ACK/ERR.

## Structure
- Shared package wb_ext_bridge_pkg: state enum, default ERR_DATA, timeout counter width constant.
- No sub-module; address decode, FSM and counter inline in one module.

## Test plan
- Read hit: adr 0x3000_0010, core returns 0x1234_5678 one cycle after gnt -> addr_o 0x10, be 4'hF, ack at cycle 3, dat_o 0x1234_5678.
- Write with gnt delayed 3 cycles: sel 4'b0011, dat 0xA5A5_A5A5 -> req held 4 cycles with stable be 0x3/wdata, ack after rvalid, we_o 1.
- Window miss: adr 0x2000_0000 -> no req_o, err_o at cycle 1, dat_o 0xDEAD_BEEF.
- Timeout: gnt_i tied 0 -> req_o drops and err_o after 256 cycles; subsequent stray rvalid ignored; next read completes normally.
- cyc_i dropped in WAIT -> rvalid accepted, no ack/err, FSM back in IDLE.
- reset_n asserted while in REQ -> req_o 0 asynchronously, state IDLE, all outputs 0.
